// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Purpose:
//   A byte FIFO that feeds an 8N1 UART transmitter. The CPU writes bytes
//   with one-cycle strobes. The serializer pops them and sends each one as
//   a 10-bit frame: a start bit, 8 data bits LSB first, and a stop bit.
//   Each bit lasts DIV = CLK_HZ/BAUD clocks.
//   While the FIFO has data, frames go out back to back with no idle gap.
//
// Parameters:
//   CLK_HZ   system clock frequency in Hz
//   BAUD     serial bit rate (CLK_HZ/BAUD must be >= 2)
//   DEPTH    FIFO entries, power of two in 2..256
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   data[7:0] in   byte to transmit, sampled when wr=1
//   wr        in   one-cycle write strobe
//   busy      out  FIFO full (count == DEPTH), combinational from count
//   empty     out  FIFO empty and serializer idle
//   overflow  out  sticky dropped-write flag (0 unless the macro is defined)
//   uart_tx   out  registered serial line, idle high
//
// Build option:
//   UART_TX_OVERFLOW_FLAG_EN  - when defined, a write that arrives while the
//                               FIFO is full, with no pop in the same cycle,
//                               sets the overflow flag. The flag stays set
//                               until reset. When the macro is undefined,
//                               overflow is tied to 0.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       wr,
    output logic       busy,
    output logic       empty,
    output logic       overflow,
    output logic       uart_tx
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [BW-1:0] DIV_M1   = BW'(DIV - 1);

    // Stop elaboration on configurations that cannot work.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
        end
        if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be a power of two in 2..256");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Registers
    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [7:0]      r_mem [DEPTH];

    // Combinational next-state values
    state_t          w_state_next;
    logic [BW-1:0]   w_baud_next;
    logic [2:0]      w_bit_next;
    logic [7:0]      w_shift_next;
    logic            w_tx_next;
    logic            w_pop;
    logic            w_push;
    logic            w_full;
    logic            w_has_data;
    logic            w_baud_end;

    assign w_full     = (r_count == FULL_CNT);
    assign w_has_data = (r_count != '0);
    assign w_baud_end = (r_baud == DIV_M1);

    // A pop frees a slot in the same cycle, so a write that lands on a pop
    // is accepted even when the FIFO is full. There is no bypass path from
    // an empty FIFO: a byte must sit in the FIFO for one cycle before it
    // can be popped.
    assign w_push = wr && (!w_full || w_pop);

    // Serializer next-state and output logic
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_tx_next   = 1'b1;
                if (w_has_data) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end

            S_START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                        w_tx_next    = r_shift[0];
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    // Chain straight into the next start bit when more data
                    // is queued, so that frames leave with no gap.
                    if (w_has_data) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_tx_next    = 1'b0;
                        w_state_next = S_START;
                    end else begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // Serializer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    // FIFO bookkeeping. The pointers wrap naturally because DEPTH is a
    // power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // The storage array has no reset. Its contents have no meaning until
    // r_count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

`ifdef UART_TX_OVERFLOW_FLAG_EN
    logic w_drop;
    logic r_overflow;

    assign w_drop = wr && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign busy    = w_full;
    assign empty   = (r_state == S_IDLE) && !w_has_data;
    assign uart_tx = r_tx;

endmodule
